// File: rtl/d_driver_mb.sv
// d_driver_mb: SD DAT-line block mover between the card bus and the block buffer.
// Handles 1- or 4-bit buses, configurable block length, multi-block transfers,
// read start-bit timeout and the write CRC-status token / busy handshake.
module d_driver_mb #(
  parameter int BUS_W      = 4,
  parameter int BLK_LEN    = 512,
  parameter int MAX_BLOCKS = 8,
  parameter int TIMEOUT    = 100000,
  parameter int ADDR_W     = 13
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [BUS_W-1:0]  idata_sd,
  output logic [BUS_W-1:0]  odata_sd,
  output logic              ooe_sd,
  input  logic              istart_read,
  input  logic              istart_write,
  input  logic [3:0]        inblocks,
  output logic [ADDR_W-1:0] oaddr,
  output logic [BUS_W-1:0]  owdata,
  output logic              owrite_en,
  input  logic [BUS_W-1:0]  irdata,
  output logic              ocrc_fail,
  output logic              otimeout,
  output logic              obusy,
  output logic              odone
);

  // Data beats per block, and a counter wide enough for beats or timeouts.
  localparam int W        = BLK_LEN * 8 / BUS_W;
  localparam int CNT_MAX0 = (W > TIMEOUT) ? W : TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > 16) ? CNT_MAX0 : 16;
  localparam int CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, RD_WAIT, RD_DATA, RD_CRC, RD_END,
    WR_PRE, WR_START, WR_DATA, WR_CRC, WR_END,
    WR_STAT_WAIT, WR_STAT, WR_BUSY, DONE
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt;
  logic [3:0]             nblk;
  logic [3:0]             nblk_start;
  logic [BUS_W-1:0][15:0] crc;
  logic [2:0]             stat;
  logic                   to_hit;
  logic                   beat_last;
  logic                   crc_last;
  logic                   stat_ok;

  // One CRC16 (x^16+x^12+x^5+1) step for a single DAT line.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ (((b ^ c[15]) != 1'b0) ? 16'h1021 : 16'h0000);
  endfunction

  assign to_hit    = (cnt == CW'(TIMEOUT - 1));
  assign beat_last = (cnt == CW'(W - 1));
  assign crc_last  = (cnt == CW'(15));
  assign stat_ok   = (stat == 3'b010) && idata_sd[0];

  // Block count latched at start: zero means one block, large values clamp.
  always_comb begin
    nblk_start = inblocks;
    if (inblocks == 4'd0)
      nblk_start = 4'd1;
    else if (int'(inblocks) > MAX_BLOCKS)
      nblk_start = 4'(MAX_BLOCKS);
  end

  // State register.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic for both read and write sequences.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (istart_read)       state_next = RD_WAIT;
        else if (istart_write) state_next = WR_PRE;
      end
      RD_WAIT: begin
        if (idata_sd == '0) state_next = RD_DATA;
        else if (to_hit)    state_next = DONE;
      end
      RD_DATA:  if (beat_last) state_next = RD_CRC;
      RD_CRC:   if (crc_last)  state_next = RD_END;
      RD_END: begin
        if (ocrc_fail || (idata_sd != '1) || (nblk <= 4'd1)) state_next = DONE;
        else                                                  state_next = RD_WAIT;
      end
      WR_PRE:   if (cnt == CW'(1)) state_next = WR_START;
      WR_START: state_next = WR_DATA;
      WR_DATA:  if (beat_last) state_next = WR_CRC;
      WR_CRC:   if (crc_last)  state_next = WR_END;
      WR_END:   state_next = WR_STAT_WAIT;
      WR_STAT_WAIT: begin
        if (!idata_sd[0]) state_next = WR_STAT;
        else if (to_hit)  state_next = DONE;
      end
      WR_STAT: begin
        if (cnt == CW'(3)) state_next = stat_ok ? WR_BUSY : DONE;
      end
      WR_BUSY: begin
        if (idata_sd[0])  state_next = (nblk > 4'd1) ? WR_PRE : DONE;
        else if (to_hit)  state_next = DONE;
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Bus-facing outputs and status strobes decoded from the current state.
  always_comb begin
    odata_sd = '1;
    ooe_sd   = 1'b0;
    case (state)
      WR_PRE:   ooe_sd = 1'b1;
      WR_START: begin ooe_sd = 1'b1; odata_sd = '0; end
      WR_DATA:  begin ooe_sd = 1'b1; odata_sd = irdata; end
      WR_CRC: begin
        ooe_sd = 1'b1;
        for (int l = 0; l < BUS_W; l++) odata_sd[l] = crc[l][15];
      end
      WR_END:   ooe_sd = 1'b1;
      default:  ;
    endcase
    obusy = (state != IDLE) && (state != DONE);
    odone = (state == DONE);
  end

  // Datapath: counters, buffer addressing, per-line CRC and error flags.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt       <= '0;
      nblk      <= '0;
      crc       <= '0;
      stat      <= '0;
      oaddr     <= '0;
      owdata    <= '0;
      owrite_en <= 1'b0;
      ocrc_fail <= 1'b0;
      otimeout  <= 1'b0;
    end else begin
      cnt       <= (state_next != state) ? '0 : cnt + CW'(1);
      owrite_en <= (state == RD_DATA);
      if (owrite_en) oaddr <= oaddr + ADDR_W'(1);
      case (state)
        IDLE: begin
          if (istart_read || istart_write) begin
            nblk      <= nblk_start;
            ocrc_fail <= 1'b0;
            otimeout  <= 1'b0;
            oaddr     <= '0;
          end
        end
        RD_WAIT: begin
          crc <= '0;
          if (to_hit && (idata_sd != '0)) otimeout <= 1'b1;
        end
        RD_DATA: begin
          owdata <= idata_sd;
          for (int l = 0; l < BUS_W; l++) crc[l] <= crc16_step(crc[l], idata_sd[l]);
        end
        RD_CRC: begin
          for (int l = 0; l < BUS_W; l++) begin
            if (idata_sd[l] != crc[l][15]) ocrc_fail <= 1'b1;
            crc[l] <= {crc[l][14:0], 1'b0};
          end
        end
        RD_END: begin
          if (idata_sd != '1) ocrc_fail <= 1'b1;
          nblk <= nblk - 4'd1;
        end
        WR_PRE:   crc <= '0;
        WR_START: oaddr <= oaddr + ADDR_W'(1);
        WR_DATA: begin
          for (int l = 0; l < BUS_W; l++) crc[l] <= crc16_step(crc[l], irdata[l]);
          if (!beat_last) oaddr <= oaddr + ADDR_W'(1);
        end
        WR_CRC: begin
          for (int l = 0; l < BUS_W; l++) crc[l] <= {crc[l][14:0], 1'b0};
        end
        WR_STAT_WAIT: begin
          if (to_hit && idata_sd[0]) otimeout <= 1'b1;
        end
        WR_STAT: begin
          if (cnt == CW'(3)) begin
            if (!stat_ok) ocrc_fail <= 1'b1;
          end else begin
            stat <= {stat[1:0], idata_sd[0]};
          end
        end
        WR_BUSY: begin
          if (idata_sd[0]) nblk <= nblk - 4'd1;
          else if (to_hit) otimeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_driver_mb.sv
// tb_d_driver_mb: scoreboard bench for d_driver_mb with directed SD bus traffic.
module tb_d_driver_mb;

  localparam int BUS_W      = 4;
  localparam int BLK_LEN    = 512;
  localparam int MAX_BLOCKS = 8;
  localparam int TIMEOUT    = 64;
  localparam int ADDR_W     = 13;
  localparam int W          = BLK_LEN * 8 / BUS_W;

  logic              clk = 1'b0;
  logic              irst;
  logic [BUS_W-1:0]  idata_sd;
  logic [BUS_W-1:0]  odata_sd;
  logic              ooe_sd;
  logic              istart_read;
  logic              istart_write;
  logic [3:0]        inblocks;
  logic [ADDR_W-1:0] oaddr;
  logic [BUS_W-1:0]  owdata;
  logic              owrite_en;
  logic [BUS_W-1:0]  irdata = '0;
  logic              ocrc_fail;
  logic              otimeout;
  logic              obusy;
  logic              odone;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { logic crc_fail; logic tmo; int at; } done_t;

  wr_t         exp_wr[$];
  int          exp_bus[$];
  done_t       exp_done[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [15:0] good_crc [BUS_W];

  d_driver_mb #(
    .BUS_W(BUS_W), .BLK_LEN(BLK_LEN), .MAX_BLOCKS(MAX_BLOCKS),
    .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)
  ) dut (
    .iclk(clk), .irst(irst), .idata_sd(idata_sd), .odata_sd(odata_sd),
    .ooe_sd(ooe_sd), .istart_read(istart_read), .istart_write(istart_write),
    .inblocks(inblocks), .oaddr(oaddr), .owdata(owdata), .owrite_en(owrite_en),
    .irdata(irdata), .ocrc_fail(ocrc_fail), .otimeout(otimeout),
    .obusy(obusy), .odone(odone)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a falling edge is the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer RAM model holding the pattern addr mod 16, one cycle read latency.
  always @(posedge clk) irdata <= oaddr[3:0];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference CRC16 per line over the nibble pattern i mod 16.
  function automatic logic [15:0] ref_crc(input int line);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < W; i++) begin
      fb = c[15] ^ (((i >> line) & 1) != 0);
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic applyStimulus(input logic [3:0] dat);
    @(negedge clk);
    idata_sd = dat;
  endtask

  task automatic start_xfer(input logic rd, input logic wr, input logic [3:0] nb, output int c);
    @(negedge clk);
    inblocks     = nb;
    istart_read  = rd;
    istart_write = wr;
    c            = cyc;
    @(negedge clk);
    istart_read  = 1'b0;
    istart_write = 1'b0;
  endtask

  task automatic push_read_writes(input int base);
    for (int i = 0; i < W; i++) exp_wr.push_back('{base + i, i % 16});
  endtask

  task automatic push_write_block();
    logic [3:0] nib;
    exp_bus.push_back(15);
    exp_bus.push_back(15);
    exp_bus.push_back(0);
    for (int i = 0; i < W; i++) exp_bus.push_back(i % 16);
    for (int j = 0; j < 16; j++) begin
      for (int l = 0; l < BUS_W; l++) nib[l] = good_crc[l][15-j];
      exp_bus.push_back(int'(nib));
    end
    exp_bus.push_back(15);
  endtask

  // Card sending one read block; flip_beat >= 0 corrupts line 2 of that CRC beat.
  task automatic send_read_block(input int flip_beat);
    logic [3:0] nib;
    applyStimulus(4'hF);
    applyStimulus(4'h0);
    for (int i = 0; i < W; i++) applyStimulus(4'(i % 16));
    for (int j = 0; j < 16; j++) begin
      for (int l = 0; l < BUS_W; l++) nib[l] = good_crc[l][15-j];
      if (j == flip_beat) nib[2] = ~nib[2];
      applyStimulus(nib);
    end
    applyStimulus(4'hF);
  endtask

  // Card answering one written block with a status token and optional busy.
  task automatic card_respond(input logic [2:0] status, input int busy,
                              output int end_c, output int rel_c);
    int n;
    n = 0;
    while (ooe_sd !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checkOutput("ooe_rise", int'(ooe_sd), 1);
    n = 0;
    while (ooe_sd !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    checkOutput("ooe_fall", int'(ooe_sd), 0);
    applyStimulus(4'hF);
    applyStimulus(4'hF);
    applyStimulus(4'hE);
    for (int k = 2; k >= 0; k--) applyStimulus({3'b111, status[k]});
    applyStimulus(4'hF);
    end_c = cyc;
    rel_c = end_c;
    if (busy > 0) begin
      repeat (busy) applyStimulus(4'hE);
      applyStimulus(4'hF);
      rel_c = cyc;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_done.size() != 0; i++) @(negedge clk);
    checkOutput("done_seen", exp_done.size(), 0);
    repeat (10) @(negedge clk);
    checkOutput("writes_all_seen", exp_wr.size(), 0);
    checkOutput("bus_all_seen", exp_bus.size(), 0);
  endtask

  // Monitor: pops expected buffer writes, bus beats and completions as they appear.
  always @(negedge clk) begin
    wr_t   e;
    done_t d;
    int    b;
    if (!irst) begin
      if (owrite_en) begin
        checkOutput("write_expected", int'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          checkOutput("wr_addr", int'(oaddr), e.addr);
          checkOutput("wr_data", int'(owdata), e.data);
        end
      end
      if (ooe_sd) begin
        checkOutput("bus_expected", int'(exp_bus.size() != 0), 1);
        if (exp_bus.size() != 0) begin
          b = exp_bus.pop_front();
          checkOutput("bus_data", int'(odata_sd), b);
        end
      end
      if (odone) begin
        checkOutput("done_expected", int'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          checkOutput("done_crc_fail", int'(ocrc_fail), int'(d.crc_fail));
          checkOutput("done_timeout", int'(otimeout), int'(d.tmo));
          checkOutput("done_cycle", cyc, d.at);
          checkOutput("done_busy_low", int'(obusy), 0);
          checkOutput("done_oe_low", int'(ooe_sd), 0);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c, e, r;
    irst         = 1'b1;
    idata_sd     = 4'hF;
    istart_read  = 1'b0;
    istart_write = 1'b0;
    inblocks     = 4'd0;
    for (int l = 0; l < BUS_W; l++) good_crc[l] = ref_crc(l);

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_oe", int'(ooe_sd), 0);
    checkOutput("rst_odata", int'(odata_sd), 15);
    checkOutput("rst_busy", int'(obusy), 0);
    checkOutput("rst_done", int'(odone), 0);
    checkOutput("rst_addr", int'(oaddr), 0);
    checkOutput("rst_wen", int'(owrite_en), 0);
    checkOutput("rst_crc_fail", int'(ocrc_fail), 0);
    checkOutput("rst_timeout", int'(otimeout), 0);
    irst = 1'b0;

    // Single-block read
    $display("[TB] single-block read");
    push_read_writes(0);
    start_xfer(1'b1, 1'b0, 4'd1, c);
    send_read_block(-1);
    exp_done.push_back('{1'b0, 1'b0, cyc + 1});
    wait_done();

    // Three-block read, second block has a bad CRC bit on line 2
    $display("[TB] multi-block read with CRC error");
    push_read_writes(0);
    push_read_writes(W);
    start_xfer(1'b1, 1'b0, 4'd3, c);
    send_read_block(-1);
    send_read_block(5);
    exp_done.push_back('{1'b1, 1'b0, cyc + 1});
    wait_done();
    checkOutput("crc_fail_hold", int'(ocrc_fail), 1);

    // Block count zero behaves as one block
    $display("[TB] read with inblocks=0");
    push_read_writes(0);
    start_xfer(1'b1, 1'b0, 4'd0, c);
    checkOutput("crc_fail_cleared", int'(ocrc_fail), 0);
    send_read_block(-1);
    exp_done.push_back('{1'b0, 1'b0, cyc + 1});
    wait_done();

    // Two-block write with good status and 50-cycle busy
    $display("[TB] two-block write");
    push_write_block();
    push_write_block();
    start_xfer(1'b0, 1'b1, 4'd2, c);
    card_respond(3'b010, 50, e, r);
    card_respond(3'b010, 50, e, r);
    exp_done.push_back('{1'b0, 1'b0, r + 1});
    wait_done();

    // Write with rejected status token
    $display("[TB] write with status 101");
    push_write_block();
    start_xfer(1'b0, 1'b1, 4'd2, c);
    card_respond(3'b101, 0, e, r);
    exp_done.push_back('{1'b1, 1'b0, e + 1});
    wait_done();

    // Simultaneous starts: read wins, then times out; a later start is ignored
    $display("[TB] read timeout with overlapping starts");
    start_xfer(1'b1, 1'b1, 4'd1, c);
    exp_done.push_back('{1'b0, 1'b1, c + 1 + TIMEOUT});
    repeat (8) @(negedge clk);
    checkOutput("busy_mid", int'(obusy), 1);
    istart_write = 1'b1;
    istart_read  = 1'b1;
    @(negedge clk);
    istart_write = 1'b0;
    istart_read  = 1'b0;
    wait_done();
    checkOutput("timeout_hold", int'(otimeout), 1);

    // Reset in the middle of a write
    $display("[TB] reset during write");
    push_write_block();
    start_xfer(1'b0, 1'b1, 4'd1, c);
    repeat (20) @(negedge clk);
    checkOutput("oe_before_reset", int'(ooe_sd), 1);
    irst = 1'b1;
    #1;
    checkOutput("mid_rst_oe", int'(ooe_sd), 0);
    checkOutput("mid_rst_odata", int'(odata_sd), 15);
    checkOutput("mid_rst_busy", int'(obusy), 0);
    checkOutput("mid_rst_done", int'(odone), 0);
    exp_bus.delete();
    repeat (2) @(negedge clk);
    irst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("idle_after_reset", int'(obusy), 0);
    checkOutput("no_pending_done", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
